uart_rx_ctrl: RTL

- Receive-side sequencer for the UART IP.
- Consumes the 16x oversampling enable from the rx baud/clock divider and the raw serial line.
- Detects start bits, majority-votes each bit at mid-bit, assembles LSB-first data with optional parity, and checks the stop bit.
- Presents each byte on a single-entry valid/ready holding register to the host-side logic.

---
 rtl/uart_rx_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: 16x-oversampled start detection, 3-point majority vote per bit,
// optional parity, stop-bit check and a single-entry valid/ready holding register.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] V0      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] V1      = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] V2      = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LASTBIT = BW'(DATA_BITS - 1);
  localparam logic          PEN     = (PARITY_EN != 0);
  localparam logic          ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_e;

  state_e               state_q, state_d;
  logic                 rxMeta_q, rxs_q;
  logic [CW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 vote0_q, vote0_d, vote1_q, vote1_d;
  logic                 perrPend_q, perrPend_d;
  logic [DATA_BITS-1:0] rxData_q, rxData_d;
  logic                 rxValid_q, rxValid_d;
  logic                 ferr_q, ferr_d, perr_q, perr_d, overrun_q, overrun_d;
  logic                 voteBit, complete, frameErrNew;

  // The third vote point is the live synchronised sample; the first two were latched earlier.
  assign voteBit = (vote0_q & vote1_q) | (vote0_q & rxs_q) | (vote1_q & rxs_q);

  always_comb begin
    state_d     = state_q;
    scnt_d      = scnt_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    vote0_d     = vote0_q;
    vote1_d     = vote1_q;
    perrPend_d  = perrPend_q;
    complete    = 1'b0;
    frameErrNew = 1'b0;
    if (sample_tick) begin
      if (scnt_q == V0) vote0_d = rxs_q;
      if (scnt_q == V1) vote1_d = rxs_q;
      scnt_d = (scnt_q == LAST) ? '0 : scnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          scnt_d = '0;
          if (!rxs_q) state_d = START;
        end
        START: begin
          if (scnt_q == V2 && voteBit) begin
            state_d = IDLE;
            scnt_d  = '0;
          end else if (scnt_q == LAST) begin
            state_d  = DATA;
            bitIdx_d = '0;
          end
        end
        DATA: begin
          if (scnt_q == V2) shift_d = {voteBit, shift_q[DATA_BITS-1:1]};
          if (scnt_q == LAST) begin
            if (bitIdx_q == LASTBIT) state_d = PEN ? PARITY : STOP;
            else bitIdx_d = bitIdx_q + 1'b1;
          end
        end
        PARITY: begin
          if (scnt_q == V2) perrPend_d = (^shift_q) ^ voteBit ^ ODD;
          if (scnt_q == LAST) state_d = STOP;
        end
        STOP: begin
          // Stop is judged at mid-bit so the next start edge can be caught early.
          if (scnt_q == V2) begin
            complete    = 1'b1;
            frameErrNew = ~voteBit;
            state_d     = voteBit ? IDLE : BREAK_WAIT;
            scnt_d      = '0;
          end
        end
        BREAK_WAIT: begin
          scnt_d = '0;
          if (rxs_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rxData_d  = rxData_q;
    rxValid_d = rxValid_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    overrun_d = 1'b0;
    if (rxValid_q && rx_ready) rxValid_d = 1'b0;
    if (complete) begin
      if (!rxValid_q || rx_ready) begin
        rxData_d  = shift_q;
        rxValid_d = 1'b1;
        ferr_d    = frameErrNew;
        perr_d    = PEN & perrPend_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta_q   <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= IDLE;
      scnt_q     <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      vote0_q    <= 1'b0;
      vote1_q    <= 1'b0;
      perrPend_q <= 1'b0;
      rxData_q   <= '0;
      rxValid_q  <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxMeta_q   <= rx_in;
      rxs_q      <= rxMeta_q;
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      vote0_q    <= vote0_d;
      vote1_q    <= vote1_d;
      perrPend_q <= perrPend_d;
      rxData_q   <= rxData_d;
      rxValid_q  <= rxValid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data    = rxData_q;
  assign rx_valid   = rxValid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule
